// File: rtl/ctrl_pkg.sv
// Purpose: shared state encoding, opcodes and control-word layout for the multi-cycle RV32I sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

  // FETCH and DECODE must sit at 0 and 1; HALT is pinned to all-ones.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_HALT     = 4'hF
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASSB  = 2'b11;

  // Everything the decoder produces from state; the branch term of pc_write is added in the top.
  typedef struct packed {
    logic       pc_update;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_word_t;

  // Dispatch target out of DECODE; unknown opcodes park the core in HALT.
  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_RTYPE:          decode_next = S_EXEC_R;
      OP_ITYPE:          decode_next = S_EXEC_I;
      OP_BRANCH:         decode_next = S_BRANCH;
      OP_JAL:            decode_next = S_JAL;
      OP_JALR:           decode_next = S_JALR;
      OP_LUI:            decode_next = S_LUI;
      OP_AUIPC:          decode_next = S_AUIPC;
      default:           decode_next = S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Purpose: bundle between the sequencer and the datapath / memory port.
// Latency: n/a (wires only).
// Backpressure: mem_ready is the only stall input.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic       branch_taken;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       halted;
  logic [3:0] state;

  // Sequencer side.
  modport master (
    input  op, branch_taken, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, halted, state
  );

  // Datapath side.
  modport slave (
    output op, branch_taken, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, halted, state
  );
endinterface

// File: rtl/ctrl_outputs.sv
// Purpose: combinational state -> control word decoder for the multi-cycle sequencer.
// Latency: 0 cycles (pure combinational).
// Backpressure: FETCH strobes qualified by mem_rdy_i so a stalled fetch changes nothing.
module ctrl_outputs
  import ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic       mem_rdy_i,
  output ctrl_word_t cw_o
);

  // Per-state control word; anything not listed stays at zero.
  always_comb begin
    cw_o = '0;
    case (state_i)
      S_FETCH: begin
        cw_o.alu_src_b  = SRCB_FOUR;
        cw_o.result_src = RES_ALU;
        cw_o.ir_write   = mem_rdy_i;
        cw_o.pc_update  = mem_rdy_i;
      end
      S_DECODE: begin
        cw_o.alu_src_a = SRCA_OLDPC;
        cw_o.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        cw_o.alu_src_a = SRCA_RS1;
        cw_o.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        cw_o.adr_src    = 1'b1;
        cw_o.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        cw_o.result_src = RES_MEMDATA;
        cw_o.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        cw_o.adr_src    = 1'b1;
        cw_o.result_src = RES_ALUOUT;
        cw_o.mem_write  = 1'b1;
      end
      S_EXEC_R: begin
        cw_o.alu_src_a = SRCA_RS1;
        cw_o.alu_src_b = SRCB_RS2;
        cw_o.alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        cw_o.alu_src_a = SRCA_RS1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        cw_o.result_src = RES_ALUOUT;
        cw_o.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        cw_o.alu_src_a  = SRCA_RS1;
        cw_o.alu_src_b  = SRCB_RS2;
        cw_o.alu_op     = ALU_SUB;
        cw_o.result_src = RES_ALUOUT;
      end
      S_JALR: begin
        cw_o.alu_src_a = SRCA_RS1;
        cw_o.alu_src_b = SRCB_IMM;
      end
      S_JAL: begin
        cw_o.alu_src_a  = SRCA_OLDPC;
        cw_o.alu_src_b  = SRCB_FOUR;
        cw_o.result_src = RES_ALUOUT;
        cw_o.pc_update  = 1'b1;
      end
      S_LUI: begin
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALU_PASSB;
      end
      S_AUIPC: begin
        cw_o.alu_src_a = SRCA_OLDPC;
        cw_o.alu_src_b = SRCB_IMM;
      end
      S_HALT: begin
        cw_o.halted = 1'b1;
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: Moore sequencer walking each RV32I instruction through fetch/decode/execute/mem/writeback.
// Latency: 3..5 cycles per instruction with memory always ready, +1 per memory wait cycle.
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE while mem_ready is low; HALT absorbs until reset.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  state_t     state_q, state_d;
  ctrl_word_t cw;
  logic       mem_rdy;

  // With the handshake disabled every access completes in one cycle.
  assign mem_rdy = USE_MEM_READY ? bus.mem_ready : 1'b1;

  // State register; reset drops straight back to FETCH, aborting any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state: memory states hold until the access completes, DECODE dispatches on opcode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_rdy) state_d = S_DECODE;
      S_DECODE:   state_d = decode_next(bus.op);
      S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
  end

  ctrl_outputs u_outputs (
    .state_i   (state_q),
    .mem_rdy_i (mem_rdy),
    .cw_o      (cw)
  );

  // Drive the bus; everything is forced quiet while reset is asserted.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.halted     = 1'b0;
    if (rst_n) begin
      bus.pc_write   = cw.pc_update | ((state_q == S_BRANCH) & bus.branch_taken);
      bus.adr_src    = cw.adr_src;
      bus.mem_write  = cw.mem_write;
      bus.ir_write   = cw.ir_write;
      bus.reg_write  = cw.reg_write;
      bus.result_src = cw.result_src;
      bus.alu_src_a  = cw.alu_src_a;
      bus.alu_src_b  = cw.alu_src_b;
      bus.alu_op     = cw.alu_op;
      bus.halted     = cw.halted;
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.USE_MEM_READY(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Observed control outputs packed into one word.
  function automatic logic [13:0] obs();
    return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
            bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.halted};
  endfunction

  // Control word each phase must present, written straight from the phase descriptions.
  function automatic logic [13:0] exp_word(input state_t s, input logic mr, input logic bt);
    logic pcw, adr, mw, irw, rw, h;
    logic [1:0] rs, a, b, aop;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; h = 0;
    rs = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
    case (s)
      S_FETCH:    begin b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      S_DECODE:   begin a = 2'b01; b = 2'b01; end
      S_MEMADR:   begin a = 2'b10; b = 2'b01; end
      S_MEMREAD:  begin adr = 1; end
      S_MEMWB:    begin rs = 2'b01; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXEC_R:   begin a = 2'b10; aop = 2'b10; end
      S_EXEC_I:   begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      S_ALUWB:    begin rw = 1; end
      S_BRANCH:   begin a = 2'b10; aop = 2'b01; pcw = bt; end
      S_JALR:     begin a = 2'b10; b = 2'b01; end
      S_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
      S_LUI:      begin b = 2'b01; aop = 2'b11; end
      S_AUIPC:    begin a = 2'b01; b = 2'b01; end
      S_HALT:     begin h = 1; end
      default:    ;
    endcase
    return {pcw, adr, mw, irw, rw, rs, a, b, aop, h};
  endfunction

  // Runs one instruction: fw fetch waits, mw memory waits. Expected path and per-instruction
  // totals come from the instruction class; each cycle is checked against the path.
  task automatic run_instr(input logic [6:0] opc, input int fw, input int mw_in,
                           input logic bt, input string nm);
    state_t path[$];
    bit is_ld, is_st, is_br, is_jmp;
    int mw, mem_start, n_ir, n_rw, n_mw, n_pw, exp_pw;
    logic mr, btc;
    logic [1:0] rs_at_rw;
    is_ld  = (opc == OP_LOAD);
    is_st  = (opc == OP_STORE);
    is_br  = (opc == OP_BRANCH);
    is_jmp = (opc == OP_JAL) || (opc == OP_JALR);
    mw = (is_ld || is_st) ? mw_in : 0;
    n_ir = 0; n_rw = 0; n_mw = 0; n_pw = 0; rs_at_rw = 2'b11;

    path = {};
    repeat (fw + 1) path.push_back(S_FETCH);
    path.push_back(S_DECODE);
    case (opc)
      OP_LOAD:   begin path.push_back(S_MEMADR); repeat (mw + 1) path.push_back(S_MEMREAD);
                       path.push_back(S_MEMWB); end
      OP_STORE:  begin path.push_back(S_MEMADR); repeat (mw + 1) path.push_back(S_MEMWRITE); end
      OP_RTYPE:  begin path.push_back(S_EXEC_R); path.push_back(S_ALUWB); end
      OP_ITYPE:  begin path.push_back(S_EXEC_I); path.push_back(S_ALUWB); end
      OP_BRANCH: path.push_back(S_BRANCH);
      OP_JAL:    begin path.push_back(S_JAL); path.push_back(S_ALUWB); end
      OP_JALR:   begin path.push_back(S_JALR); path.push_back(S_JAL); path.push_back(S_ALUWB); end
      OP_LUI:    begin path.push_back(S_LUI); path.push_back(S_ALUWB); end
      default:   begin path.push_back(S_AUIPC); path.push_back(S_ALUWB); end
    endcase

    mem_start = fw + 3;
    foreach (path[c]) begin
      if (c < fw || (c >= mem_start && c < mem_start + mw)) mr = 1'b0;
      else if (c == fw || ((is_ld || is_st) && c == mem_start + mw)) mr = 1'b1;
      else mr = 1'($urandom);
      btc = is_br ? bt : 1'($urandom);
      bus.op = opc; bus.mem_ready = mr; bus.branch_taken = btc;
      @(negedge clk);
      chk({nm, "_state"}, 32'(bus.state), 32'(path[c]));
      chk({nm, "_ctl"}, 32'(obs()), 32'(exp_word(path[c], mr, btc)));
      if (bus.ir_write)  n_ir++;
      if (bus.mem_write) n_mw++;
      if (bus.pc_write)  n_pw++;
      if (bus.reg_write) begin n_rw++; rs_at_rw = bus.result_src; end
      @(posedge clk); #1;
    end

    exp_pw = 1 + (is_jmp ? 1 : 0) + ((is_br && bt) ? 1 : 0);
    chk({nm, "_n_ir"}, n_ir, 1);
    chk({nm, "_n_rw"}, n_rw, (is_st || is_br) ? 0 : 1);
    chk({nm, "_n_mw"}, n_mw, is_st ? mw + 1 : 0);
    chk({nm, "_n_pw"}, n_pw, exp_pw);
    if (!is_st && !is_br) chk({nm, "_rs_wb"}, 32'(rs_at_rw), is_ld ? 32'd1 : 32'd0);
  endtask

  logic [6:0] ops [9] = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
                          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  initial begin
    rst_n = 1'b0;
    bus.op = OP_RTYPE; bus.mem_ready = 1'b1; bus.branch_taken = 1'b1;
    #12;
    chk("rst_state", 32'(bus.state), 32'(S_FETCH));
    chk("rst_ctl", 32'(obs()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr(OP_RTYPE, 0, 0, 1'b0, "add");
    run_instr(OP_LOAD, 2, 3, 1'b0, "lw");
    // A 10-cycle load must be over here: the core is back in FETCH.
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("lw_end", 32'(bus.state), 32'(S_FETCH));
    @(posedge clk); #1;
    run_instr(OP_BRANCH, 0, 0, 1'b1, "beq_t");
    run_instr(OP_BRANCH, 0, 0, 1'b0, "beq_nt");
    run_instr(OP_JALR, 0, 0, 1'b0, "jalr");
    run_instr(OP_JAL, 1, 0, 1'b0, "jal");
    run_instr(OP_STORE, 1, 2, 1'b0, "sw");
    run_instr(OP_LUI, 0, 0, 1'b0, "lui");
    run_instr(OP_AUIPC, 0, 0, 1'b0, "auipc");
    run_instr(OP_ITYPE, 0, 0, 1'b0, "addi");

    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 8);
      run_instr(ops[k], $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), "rnd");
    end

    // Reset in the middle of a stalled store.
    bus.op = OP_STORE; bus.branch_taken = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.mem_ready = (c == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 3) begin
        chk("rstw_pre_state", 32'(bus.state), 32'(S_MEMWRITE));
        chk("rstw_pre_mw", 32'(bus.mem_write), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw_state", 32'(bus.state), 32'(S_FETCH));
        chk("rstw_mw", 32'(bus.mem_write), 32'd0);
        chk("rstw_ctl", 32'(obs()), 32'd0);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("rstw_rel_state", 32'(bus.state), 32'(S_FETCH));
    chk("rstw_rel_ctl", 32'(obs()), 32'(exp_word(S_FETCH, 1'b0, 1'b0)));
    @(posedge clk); #1;

    // Unsupported opcode parks the core.
    bus.op = 7'b0000000; bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("halt_fetch", 32'(bus.state), 32'(S_FETCH));
    @(posedge clk); #1;
    @(negedge clk);
    chk("halt_decode", 32'(bus.state), 32'(S_DECODE));
    @(posedge clk); #1;
    for (int c = 0; c < 100; c++) begin
      bus.mem_ready = c[0];
      bus.branch_taken = 1'($urandom);
      bus.op = 7'($urandom);
      @(negedge clk);
      chk("halt_state", 32'(bus.state), 32'(S_HALT));
      chk("halt_ctl", 32'(obs()), 32'(14'b1));
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("halt_rst_state", 32'(bus.state), 32'(S_FETCH));
    chk("halt_rst_halted", 32'(bus.halted), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr(OP_RTYPE, 0, 0, 1'b0, "post_halt");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
